// File: rtl/escape_decoder_if.sv
// escape_decoder_if: host byte stream handshake (data/valid/ready) feeding the escape decoder.
//   master: byte source drives data/valid, sees ready; slave: decoder side.
interface escape_decoder_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/escape_decoder.sv
// escape_decoder: VT52 host-byte interpreter driving character buffer writes, cursor and scroll requests.
//   clk, reset (sync, active-high); host: escape_decoder_if.slave byte stream (data/valid/ready);
//   buf_din/buf_waddr/buf_wen: buffer write port; scroll/scroll_done: scroll request and completion;
//   cursor_row/cursor_col: cursor for the overlay. Define VT52_ERASE_EN to build the ESC J/K erase.
module escape_decoder #(
  parameter int ADDR_BITS = 11,
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  escape_decoder_if.slave      host,
  output logic [7:0]           buf_din,
  output logic [ADDR_BITS-1:0] buf_waddr,
  output logic                 buf_wen,
  output logic                 scroll,
  input  logic                 scroll_done,
  output logic [4:0]           cursor_row,
  output logic [6:0]           cursor_col
);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [7:0] ROWS_B = 8'(ROWS);
  localparam logic [7:0] COLS_B = 8'(COLS);
  localparam logic [ADDR_BITS-1:0] COLS_A = ADDR_BITS'(COLS);
  typedef enum logic [2:0] {IDLE, ESC, YROW, YCOL, ERASE, SCROLL_WAIT} state_t;
  state_t state, state_n;
  logic [4:0] row_n;
  logic [6:0] col_n;
  logic [7:0] din_n, v, tab;
  logic [ADDR_BITS-1:0] waddr_n, cur_addr, row_base;
  logic wen_n, scroll_n, take, in_row, in_col;
  assign take = host.valid && host.ready;
  assign row_base = ADDR_BITS'(cursor_row) * COLS_A;
  assign cur_addr = row_base + ADDR_BITS'(cursor_col);
  // bytes below 0x20 must not wrap into range, hence the explicit lower bound
  assign v = host.data - 8'h20;
  assign in_row = host.data >= 8'h20 && v < ROWS_B;
  assign in_col = host.data >= 8'h20 && v < COLS_B;
  assign tab = ({1'b0, cursor_col} | 8'h07) + 8'h01;
`ifdef VT52_ERASE_EN
  localparam logic [ADDR_BITS-1:0] SCREEN_END = ADDR_BITS'(ROWS * COLS - 1);
  localparam logic [ADDR_BITS-1:0] COLS_M1 = ADDR_BITS'(COLS - 1);
  logic [ADDR_BITS-1:0] erase_end, end_n;
  always_ff @(posedge clk) erase_end <= reset ? '0 : end_n;
`endif
  always_comb begin
    state_n = state;
    row_n = cursor_row;
    col_n = cursor_col;
    din_n = buf_din;
    waddr_n = buf_waddr;
    wen_n = 1'b0;
    scroll_n = 1'b0;
`ifdef VT52_ERASE_EN
    end_n = erase_end;
`endif
    case (state)
      IDLE: if (take) begin
        if (host.data >= 8'h20 && host.data <= 8'h7e) begin
          wen_n = 1'b1;
          din_n = host.data;
          waddr_n = cur_addr;
          col_n = cursor_col == LAST_COL ? cursor_col : cursor_col + 7'd1;
        end else if (host.data == 8'h0d) col_n = '0;
        else if (host.data == 8'h0a) begin
          row_n = cursor_row == LAST_ROW ? cursor_row : cursor_row + 5'd1;
          scroll_n = cursor_row == LAST_ROW;
          state_n = cursor_row == LAST_ROW ? SCROLL_WAIT : IDLE;
        end else if (host.data == 8'h08) col_n = cursor_col == '0 ? cursor_col : cursor_col - 7'd1;
        else if (host.data == 8'h09) col_n = tab > {1'b0, LAST_COL} ? LAST_COL : tab[6:0];
        else if (host.data == 8'h1b) state_n = ESC;
      end
      ESC: if (take) begin
        state_n = IDLE;
        case (host.data)
          "A": row_n = cursor_row == '0 ? cursor_row : cursor_row - 5'd1;
          "B": row_n = cursor_row == LAST_ROW ? cursor_row : cursor_row + 5'd1;
          "C": col_n = cursor_col == LAST_COL ? cursor_col : cursor_col + 7'd1;
          "D": col_n = cursor_col == '0 ? cursor_col : cursor_col - 7'd1;
          "H": begin
            row_n = '0;
            col_n = '0;
          end
`ifdef VT52_ERASE_EN
          // first blank is written straight away; ERASE walks buf_waddr up to erase_end
          "J", "K": begin
            state_n = ERASE;
            wen_n = 1'b1;
            din_n = 8'h20;
            waddr_n = cur_addr;
            end_n = host.data == "J" ? SCREEN_END : row_base + COLS_M1;
          end
`endif
          "Y": state_n = YROW;
          default: ;
        endcase
      end
      YROW: if (take) begin
        row_n = in_row ? v[4:0] : cursor_row;
        state_n = YCOL;
      end
      YCOL: if (take) begin
        col_n = in_col ? v[6:0] : cursor_col;
        state_n = IDLE;
      end
`ifdef VT52_ERASE_EN
      ERASE: if (buf_waddr == erase_end) state_n = IDLE;
      else begin
        wen_n = 1'b1;
        waddr_n = buf_waddr + ADDR_BITS'(1);
      end
`endif
      SCROLL_WAIT: if (scroll_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // ready is registered so it stays low for the first cycle after reset releases
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      host.ready <= 1'b0;
      buf_din <= 8'h20;
      buf_waddr <= '0;
      buf_wen <= 1'b0;
      scroll <= 1'b0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      state <= state_n;
      host.ready <= state_n != ERASE && state_n != SCROLL_WAIT;
      buf_din <= din_n;
      buf_waddr <= waddr_n;
      buf_wen <= wen_n;
      scroll <= scroll_n;
      cursor_row <= row_n;
      cursor_col <= col_n;
    end
  end
endmodule
